// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: fetch FSM states, IF/ID slot bundle,
// bubble instruction word and a word-alignment helper.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc_plus_4;
        logic        interrupt;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] word_align(
        input logic [31:0] a
    );
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a new slot, insert a bubble, or hold.
// Ports: clk, rst_n (sync, active low), i_load, i_bubble, i_slot -> o_slot.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_load,
    input  logic   i_bubble,
    input  if_id_t i_slot,
    output if_id_t o_slot
);

    if_id_t r_slot;

    // A bubble keeps the stale pc_plus_4; decode ignores it
    // whenever valid is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot.pc_plus_4 <= 32'h0;
            r_slot.interrupt <= 1'b0;
            r_slot.instr     <= NOP_INSTR;
            r_slot.valid     <= 1'b0;
        end else if (i_load) begin
            r_slot <= i_slot;
        end else if (i_bubble) begin
            r_slot.interrupt <= 1'b0;
            r_slot.instr     <= NOP_INSTR;
            r_slot.valid     <= 1'b0;
        end
    end

    assign o_slot = r_slot;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/rdy handshake, redirects,
// stall skid buffer, wrong-path discard and interrupt injection.
// Inputs : clk, rst_n, stall, branch_sel/branch_pc, pcr_take/ret_pc,
//          ext_int, returni_done, imem_rdy, imem_rdata.
// Outputs: imem_req, imem_addr, IF/ID {pc_plus_4, interrupt, instr,
//          if_valid}, in_isr.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] INT_VEC   = 32'h0000_0100,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_sel,
    input  logic [31:0] branch_pc,
    input  logic        pcr_take,
    input  logic [31:0] ret_pc,
    input  logic        ext_int,
    input  logic        returni_done,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_plus_4,
    output logic        interrupt,
    output logic [31:0] instr,
    output logic        if_valid,
    output logic        in_isr
);

    fetch_state_e r_state;
    fetch_state_e w_state_nx;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nx;
    logic [31:0]  r_redir_pc;
    logic [31:0]  w_redir_pc_nx;
    logic         r_drop;
    logic         w_drop_nx;
    logic         r_in_isr;
    logic         r_int_pending;
    if_id_t       r_skid;
    if_id_t       w_skid_nx;

    logic         w_redir;
    logic [31:0]  w_target;
    logic         w_xfer;
    logic [31:0]  w_pc_inc;
    logic         w_take;
    logic         w_load;
    logic         w_bubble;
    if_id_t       w_slot_d;
    if_id_t       w_slot_q;

    assign w_redir  = (branch_sel | pcr_take) & ~stall;
    assign w_target = word_align(pcr_take ? ret_pc : branch_pc);
    assign w_xfer   = (r_state == FETCH) & imem_rdy;
    assign w_pc_inc = r_pc + 32'd4;

    assign imem_req  = (r_state == FETCH);
    assign imem_addr = r_pc;

    always_comb begin
        w_state_nx    = r_state;
        w_pc_nx       = r_pc;
        w_redir_pc_nx = r_redir_pc;
        w_drop_nx     = r_drop;
        w_skid_nx     = r_skid;
        w_take        = 1'b0;
        w_load        = 1'b0;
        w_bubble      = 1'b0;
        w_slot_d      = '{pc_plus_4: w_pc_inc,
                          interrupt: 1'b0,
                          instr:     imem_rdata,
                          valid:     1'b1};

        unique case (r_state)
            FETCH: begin
                if (w_redir && w_xfer) begin
                    w_bubble  = 1'b1;
                    w_pc_nx   = w_target;
                    w_drop_nx = 1'b0;
                end else if (w_redir) begin
                    // Address must stay put until rdy; remember
                    // where to go once the old word arrives.
                    w_bubble      = 1'b1;
                    w_redir_pc_nx = w_target;
                    w_drop_nx     = 1'b1;
                end else if (w_xfer && r_drop) begin
                    w_bubble  = ~stall;
                    w_pc_nx   = r_redir_pc;
                    w_drop_nx = 1'b0;
                end else if (w_xfer && stall) begin
                    w_skid_nx  = w_slot_d;
                    w_pc_nx    = w_pc_inc;
                    w_state_nx = HOLD;
                end else if (w_xfer && r_int_pending && !r_in_isr) begin
                    // Fetched word is dropped; its address is the
                    // resume point after the handler returns.
                    w_load   = 1'b1;
                    w_take   = 1'b1;
                    w_slot_d = '{pc_plus_4: r_pc,
                                 interrupt: 1'b1,
                                 instr:     NOP_INSTR,
                                 valid:     1'b1};
                    w_pc_nx  = word_align(INT_VEC);
                end else if (w_xfer) begin
                    w_load  = 1'b1;
                    w_pc_nx = w_pc_inc;
                end else if (!stall) begin
                    w_bubble = 1'b1;
                end
            end
            HOLD: begin
                if (w_redir) begin
                    w_bubble   = 1'b1;
                    w_pc_nx    = w_target;
                    w_state_nx = FETCH;
                end else if (!stall) begin
                    w_load     = 1'b1;
                    w_slot_d   = r_skid;
                    w_state_nx = FETCH;
                end
            end
            default: begin
                w_state_nx = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= FETCH;
            r_pc          <= word_align(RESET_PC);
            r_redir_pc    <= 32'h0;
            r_drop        <= 1'b0;
            r_in_isr      <= 1'b0;
            r_int_pending <= 1'b0;
            r_skid        <= '{pc_plus_4: 32'h0,
                               interrupt: 1'b0,
                               instr:     NOP_INSTR,
                               valid:     1'b0};
        end else begin
            r_state    <= w_state_nx;
            r_pc       <= w_pc_nx;
            r_redir_pc <= w_redir_pc_nx;
            r_drop     <= w_drop_nx;
            r_skid     <= w_skid_nx;

            // A take in the same cycle as returni_done wins.
            if (w_take)
                r_in_isr <= 1'b1;
            else if (returni_done)
                r_in_isr <= 1'b0;

            if (w_take)
                r_int_pending <= 1'b0;
            else if (ext_int && !r_in_isr)
                r_int_pending <= 1'b1;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_slot   (w_slot_d),
        .o_slot   (w_slot_q)
    );

    assign pc_plus_4 = w_slot_q.pc_plus_4;
    assign interrupt = w_slot_q.interrupt;
    assign instr     = w_slot_q.instr;
    assign if_valid  = w_slot_q.valid;
    assign in_isr    = r_in_isr;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations
// plus randomized traffic against a transaction-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] INT_VEC = 32'h0000_0100;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_sel;
    logic [31:0] branch_pc;
    logic        pcr_take;
    logic [31:0] ret_pc;
    logic        ext_int;
    logic        returni_done;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_rdata;
    logic [31:0] pc_plus_4;
    logic        interrupt;
    logic [31:0] instr;
    logic        if_valid;
    logic        in_isr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'hA;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_stage #(
        .RESET_PC  (32'h0),
        .INT_VEC   (INT_VEC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_sel   (branch_sel),
        .branch_pc    (branch_pc),
        .pcr_take     (pcr_take),
        .ret_pc       (ret_pc),
        .ext_int      (ext_int),
        .returni_done (returni_done),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdy     (imem_rdy),
        .imem_rdata   (imem_rdata),
        .pc_plus_4    (pc_plus_4),
        .interrupt    (interrupt),
        .instr        (instr),
        .if_valid     (if_valid),
        .in_isr       (in_isr)
    );

    // Reference model: address being fetched, words parked while
    // decode stalls, redirect targets waiting on an in-flight word.
    bit          m_init = 0;
    logic [31:0] m_pc;
    logic [31:0] q_skid[$];
    logic [31:0] q_tgt[$];
    bit          m_isr;
    bit          m_pend;
    bit          e_valid;
    bit          e_int;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic m_bubble();
        e_valid = 0;
        e_int   = 0;
        e_instr = NOP;
    endtask

    task automatic m_issue(input logic [31:0] a);
        e_valid = 1;
        e_int   = 0;
        e_instr = mem_word(a);
        e_pc4   = a + 32'd4;
    endtask

    task automatic model_step();
        bit          redir;
        bit          done;
        bit          take;
        logic [31:0] tgt;
        if (!rst_n) begin
            m_init = 1;
            m_pc   = 32'h0;
            q_skid.delete();
            q_tgt.delete();
            m_isr  = 0;
            m_pend = 0;
            m_bubble();
            e_pc4  = 32'h0;
            return;
        end
        if (!m_init) return;
        redir = (branch_sel || pcr_take) && !stall;
        tgt   = (pcr_take ? ret_pc : branch_pc) & 32'hFFFF_FFFC;
        done  = (q_skid.size() == 0) && imem_rdy;
        take  = 0;
        if (q_skid.size() != 0) begin
            if (redir) begin
                q_skid.delete();
                m_bubble();
                m_pc = tgt;
            end else if (!stall) begin
                m_issue(q_skid.pop_front());
            end
        end else if (redir) begin
            m_bubble();
            q_tgt.delete();
            if (done) m_pc = tgt;
            else q_tgt.push_back(tgt);
        end else if (done && q_tgt.size() != 0) begin
            m_pc = q_tgt.pop_front();
            if (!stall) m_bubble();
        end else if (done && stall) begin
            q_skid.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end else if (done && m_pend && !m_isr) begin
            e_valid = 1;
            e_int   = 1;
            e_instr = NOP;
            e_pc4   = m_pc;
            m_pc    = INT_VEC;
            take    = 1;
        end else if (done) begin
            m_issue(m_pc);
            m_pc = m_pc + 32'd4;
        end else if (!stall) begin
            m_bubble();
        end
        if (take) m_pend = 0;
        else if (ext_int && !m_isr) m_pend = 1;
        if (take) m_isr = 1;
        else if (returni_done) m_isr = 0;
    endtask

    task automatic compare();
        chk("m_req", imem_req, q_skid.size() == 0);
        chk("m_addr", imem_addr, m_pc);
        chk("m_valid", if_valid, e_valid);
        chk("m_int", interrupt, e_int);
        chk("m_instr", instr, e_instr);
        chk("m_isr", in_isr, m_isr);
        if (e_valid) chk("m_pc4", pc_plus_4, e_pc4);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (m_init) compare();
    endtask

    initial begin
        rst_n        = 0;
        stall        = 0;
        branch_sel   = 0;
        branch_pc    = 0;
        pcr_take     = 0;
        ret_pc       = 0;
        ext_int      = 0;
        returni_done = 0;
        imem_rdy     = 1;
        cycle();
        cycle();
        chk("rst_valid", if_valid, 0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc4", pc_plus_4, 0);
        chk("rst_int", interrupt, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_isr", in_isr, 0);
        chk("rst_req", imem_req, 1);

        // Straight-line fetch from reset
        rst_n = 1;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk("t1_instr", instr, 32'hA + k - 1);
            chk("t1_pc4", pc_plus_4, 4 * k);
            chk("t1_valid", if_valid, 1);
        end

        // Stall with the fetch of 0x8 completing into the skid
        rst_n = 0;
        cycle();
        rst_n = 1;
        cycle();
        cycle();
        chk("t2_addr", imem_addr, 32'h8);
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t2_req", imem_req, 0);
            chk("t2_hold", instr, 32'hB);
            chk("t2_hpc4", pc_plus_4, 32'h8);
        end
        stall = 0;
        cycle();
        chk("t2_w8", instr, 32'hC);
        chk("t2_w8pc", pc_plus_4, 32'hC);
        cycle();
        chk("t2_wC", instr, 32'hD);
        chk("t2_wCpc", pc_plus_4, 32'h10);

        // Branch while the memory is not ready
        imem_rdy   = 0;
        branch_sel = 1;
        branch_pc  = 32'h40;
        cycle();
        chk("t3_addr0", imem_addr, 32'h10);
        chk("t3_bub0", if_valid, 0);
        branch_sel = 0;
        cycle();
        chk("t3_addr1", imem_addr, 32'h10);
        chk("t3_bub1", if_valid, 0);
        imem_rdy = 1;
        cycle();
        chk("t3_addr2", imem_addr, 32'h40);
        chk("t3_bub2", if_valid, 0);
        cycle();
        chk("t3_instr", instr, 32'h1A);
        chk("t3_pc4", pc_plus_4, 32'h44);

        // Return beats branch; low target bits forced to zero
        pcr_take   = 1;
        ret_pc     = 32'h1234;
        branch_sel = 1;
        branch_pc  = 32'h80;
        cycle();
        chk("t4_addr", imem_addr, 32'h1234);
        chk("t4_bub", if_valid, 0);
        pcr_take  = 0;
        branch_pc = 32'h203;
        cycle();
        chk("t4_align", imem_addr, 32'h200);

        // PC wrap at the top of the address space
        branch_pc = 32'hFFFF_FFFC;
        cycle();
        branch_sel = 0;
        cycle();
        chk("wrap_instr", instr, 32'h4000_0009);
        chk("wrap_pc4", pc_plus_4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Interrupt injection and masking
        branch_sel = 1;
        branch_pc  = 32'h1C;
        cycle();
        branch_sel = 0;
        ext_int    = 1;
        cycle();
        chk("t5_pre", pc_plus_4, 32'h20);
        ext_int = 0;
        cycle();
        chk("t5_int", interrupt, 1);
        chk("t5_pc4", pc_plus_4, 32'h20);
        chk("t5_nop", instr, NOP);
        chk("t5_valid", if_valid, 1);
        chk("t5_vec", imem_addr, 32'h100);
        chk("t5_isr", in_isr, 1);
        ext_int = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            ext_int = 0;
            chk("t5_mask", interrupt, 0);
        end
        returni_done = 1;
        cycle();
        returni_done = 0;
        chk("t5_unmask", in_isr, 0);
        ext_int = 1;
        cycle();
        ext_int = 0;
        cycle();
        chk("t5_int2", interrupt, 1);
        chk("t5_pc4b", pc_plus_4, 32'h114);
        chk("t5_isr2", in_isr, 1);

        // Reset while parked in HOLD with a full skid
        stall = 1;
        cycle();
        chk("t6_hold", imem_req, 0);
        rst_n = 0;
        cycle();
        chk("t6_valid", if_valid, 0);
        chk("t6_instr", instr, NOP);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_isr", in_isr, 0);
        chk("t6_req", imem_req, 1);
        stall = 0;
        rst_n = 1;

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst_n        = ($urandom_range(0, 199) != 0);
            stall        = ($urandom_range(0, 3) == 0);
            branch_sel   = ($urandom_range(0, 9) == 0);
            pcr_take     = ($urandom_range(0, 19) == 0);
            branch_pc    = $urandom;
            ret_pc       = $urandom;
            imem_rdy     = ($urandom_range(0, 9) < 7);
            ext_int      = ($urandom_range(0, 9) == 0);
            returni_done = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage: owns the PC and issues requests to instruction memory over a req/rdy handshake.
- Drives the IF/ID pipeline register that the decode stage consumes: resume/next PC, interrupt marker, instruction word.
- Accepts redirects back from decode (branch target, or return target for a return instruction).
- Handles hazard stalls, wrong-path discard and external-interrupt injection.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- INT_VEC, 32'h0000_0100, interrupt handler entry PC.
- NOP_INSTR, 32'h0000_0000, instruction word placed in bubbles and interrupt slots.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- stall  in  1  hazard unit: hold the IF/ID register and PC
- branch_sel  in  1  decode: take branch_pc
- branch_pc  in  32  decode branch target
- pcr_take  in  1  decode: return, take ret_pc
- ret_pc  in  32  return target (R15 value from decode)
- ext_int  in  1  external interrupt, level
- returni_done  in  1  pulse: return-from-interrupt retired, unmask interrupts
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_rdy  in  1  memory accepts and returns data this cycle
- imem_rdata  in  32  instruction word, valid when imem_req && imem_rdy
- pc_plus_4  out  32  IF/ID: address of next sequential instruction, or resume PC on an interrupt slot
- interrupt  out  1  IF/ID: slot is an interrupt injection
- instr  out  32  IF/ID instruction
- if_valid  out  1  IF/ID slot holds a real instruction or an interrupt slot
- in_isr  out  1  interrupts masked

Behaviour:
- **Reset** (rst_n=0 at posedge):
  - pc=RESET_PC, state=FETCH.
  - pc_plus_4=0, interrupt=0, instr=NOP_INSTR, if_valid=0.
  - in_isr=0, int_pending=0, drop=0, skid empty.
  - Reset mid-transfer abandons the transfer; any imem_rdy in that cycle is ignored.
- **Redirect**:
  - redir = (branch_sel | pcr_take) & ~stall.
  - Target = pcr_take ? ret_pc : branch_pc; pcr_take wins if both are asserted.
  - Redirect is ignored while stall=1; decode holds and reasserts it.
- **States**: FETCH, HOLD.
- **FETCH**:
  - imem_req=1, imem_addr=pc.
  - imem_addr is held stable until imem_rdy, even if a redirect arrives meanwhile.
  - A transfer completes on a cycle with req & rdy.
- **Per-cycle priority in FETCH**:
  1. redir & transfer completes: discard data. IF/ID <= bubble (if_valid=0, instr=NOP_INSTR, interrupt=0). pc<=target, drop<=0.
  2. redir & no completion: IF/ID <= bubble. Save target in redir_pc, set drop=1. Keep requesting the old address.
  3. Completion & drop: discard data, pc<=redir_pc, drop<=0. IF/ID unchanged if stall=1, else bubble.
  4. Completion & stall: data into skid, pc<=pc+4, state<=HOLD. IF/ID held.
  5. Completion & int_pending & ~in_isr & ~stall: interrupt slot. IF/ID <= {pc_plus_4=pc (resume address of the discarded word), interrupt=1, instr=NOP_INSTR, if_valid=1}. pc<=INT_VEC, in_isr<=1, int_pending<=0.
  6. Completion otherwise: IF/ID <= {pc+4, 0, imem_rdata, 1}, pc<=pc+4.
  7. No completion & ~stall: IF/ID <= bubble. With stall=1, IF/ID holds.
- **HOLD**:
  - imem_req=0.
  - redir: discard skid, IF/ID <= bubble, pc<=target, state<=FETCH.
  - ~stall: IF/ID <= skid {addr+4, 0, word, 1}, state<=FETCH.
  - Pending interrupts wait for the next FETCH completion.
- **Interrupt pending and mask**:
  - int_pending is set when ext_int=1 and in_isr=0; it stays set until taken.
  - Interrupts are not taken while drop=1.
  - returni_done clears in_isr. If returni_done and a take happen in the same cycle, in_isr ends at 1.
- **Arithmetic**: pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0. imem_addr[1:0] is always 00; target bits [1:0] are forced to 0.
- **Latency**: zero-wait memory gives one instruction per cycle into IF/ID; the first instruction appears 1 cycle after reset release.

Decomposition:
- Package cpu_pkg: NOP_INSTR constant, fetch state enum (FETCH/HOLD), IF/ID slot struct {pc_plus_4, interrupt, instr, valid}.
- One sub-module: if_id_reg — holds the slot with load/hold/bubble controls and synchronous active-low reset.
- PC/FSM logic stays in fetch_stage.

Test Plan:
1. Reset release, imem_rdy=1, words 0xA..0xD at 0x0..0xC.
   - instr 0xA..0xD on consecutive cycles.
   - pc_plus_4 = 0x4, 0x8, 0xC, 0x10.
   - if_valid=1 throughout.
2. stall=1 for 3 cycles mid-stream at pc=0x8, memory ready.
   - IF/ID holds the 0x4 slot.
   - Word at 0x8 is fetched once into skid; imem_req=0 during HOLD.
   - After release, instr=word@0x8 then word@0xC, with no duplicate or lost word.
3. branch_sel=1, branch_pc=0x40 while imem_rdy=0 for 2 more cycles at addr 0x10.
   - imem_addr stays 0x10 until rdy; that word is discarded.
   - Next imem_addr=0x40; bubbles (if_valid=0) in between.
4. pcr_take=1, ret_pc=0x1234, with branch_sel=1 the same cycle.
   - Next imem_addr=0x1234.
5. ext_int pulse for 1 cycle at pc=0x20.
   - Slot {interrupt=1, pc_plus_4=0x20, instr=NOP, valid=1}.
   - Next imem_addr=0x100, in_isr=1.
   - Second ext_int is ignored until returni_done; after it, a new ext_int is taken.
6. rst_n=0 during HOLD with skid full.
   - Next cycle: if_valid=0, instr=NOP_INSTR, imem_addr=RESET_PC, in_isr=0.
